// File: rtl/vga_text_pal_avl_interface.sv
// rtl/vga_text_pal_avl_interface.sv - Avalon-MM text-mode VGA controller with VRAM, palette, cursor and scroll
module font_rom (
    input  logic [10:0] addr,
    output logic [7:0]  data
);
    // Stand-in glyph table: code 0 blank, code 0x7F solid, other codes a row/code pattern.
    always_comb begin
        data = {addr[3:0], addr[7:4]};
        if (addr[10:4] == 7'h00) data = 8'h00;
        else if (addr[10:4] == 7'h7F) data = 8'hFF;
    end
endmodule

module vga_text_pal_avl_interface #(
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter int ADDR_W     = 12,
    parameter int BLINK_LOG2 = 5,
    parameter int H_VIS      = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VIS      = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              AVL_READ,
    input  logic              AVL_WRITE,
    input  logic              AVL_CS,
    input  logic [3:0]        AVL_BYTE_EN,
    input  logic [ADDR_W-1:0] AVL_ADDR,
    input  logic [31:0]       AVL_WRITEDATA,
    output logic [31:0]       AVL_READDATA,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              hs,
    output logic              vs
);
    localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW     = $clog2(H_TOT);
    localparam int VW     = $clog2(V_TOT);
    localparam int VWORDS = COLS * ROWS / 2;
    localparam int VA_W   = (VWORDS > 1) ? $clog2(VWORDS) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_VISC = HW'(H_VIS);
    localparam logic [HW-1:0] H_SS   = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_VISC = VW'(V_VIS);
    localparam logic [VW-1:0] V_SS   = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_VIS + V_FP + V_SYNC);
    localparam logic [31:0]   CTRL_MASK = 32'h1F03_FFFF;

    typedef struct packed {
        logic       act;
        logic       hs;
        logic       vs;
        logic       cur;
        logic [2:0] px;
    } ctl_t;
    localparam ctl_t CTL_RST = '{act: 1'b0, hs: 1'b1, vs: 1'b1, cur: 1'b0, px: 3'd0};

    logic            pix_en_q, pix_en_d;
    logic [HW-1:0]   h_q, h_d;
    logic [VW-1:0]   v_q, v_d;
    logic [31:0]     ctrl_q, ctrl_d;
    logic [7:0]      frame_cnt_q, frame_cnt_d;
    logic            vsync_tog_q, vsync_tog_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            rd_vram_q, rd_vram_d;
    logic [11:0]     pal_q [16];
    logic [31:0]     vram [VWORDS];
    logic [31:0]     vram_a_q, vram_b_q;
    ctl_t            s1_ctl_q, s1_ctl_d, s2_ctl_q, s2_ctl_d;
    logic            s1_half_q, s1_half_d;
    logic [3:0]      s1_row_q, s1_row_d;
    logic [7:0]      s2_glyph_q, s2_glyph_d;
    logic            s2_inv_q, s2_inv_d;
    logic [11:0]     s2_fg_q, s2_fg_d, s2_bg_q, s2_bg_d;
    logic [7:0]      red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic            hs_q, hs_d, vs_q, vs_d;

    logic              wr, rd, is_reg, is_vram, is_pal, is_ctrl, is_stat;
    logic [ADDR_W-2:0] off;
    logic [VA_W-1:0]   vaddr, fetch_addr;
    logic [31:0]       bmask;
    logic              active, hs_raw, vs_raw, cur_hit, on;
    logic [7:0]        vrow, eff, rsum, trow, glyph;
    logic [15:0]       fetch_full, ch;
    logic [11:0]       colour;

    always_comb begin
        wr      = AVL_WRITE && AVL_CS;
        rd      = AVL_READ && AVL_CS;
        is_reg  = AVL_ADDR[ADDR_W-1];
        off     = AVL_ADDR[ADDR_W-2:0];
        vaddr   = AVL_ADDR[VA_W-1:0];
        is_vram = !is_reg && (AVL_ADDR < ADDR_W'(VWORDS));
        is_pal  = is_reg && (off < (ADDR_W-1)'(16));
        is_ctrl = is_reg && (off == (ADDR_W-1)'(16));
        is_stat = is_reg && (off == (ADDR_W-1)'(17));
        bmask   = {{8{AVL_BYTE_EN[3]}}, {8{AVL_BYTE_EN[2]}}, {8{AVL_BYTE_EN[1]}}, {8{AVL_BYTE_EN[0]}}};

        ctrl_d = ctrl_q;
        if (wr && is_ctrl) ctrl_d = ((ctrl_q & ~bmask) | (AVL_WRITEDATA & bmask)) & CTRL_MASK;

        // Register reads are sampled here, so a same-cycle write is seen only by later reads.
        rdata_d   = rdata_q;
        rd_vram_d = rd_vram_q;
        if (rd) begin
            rd_vram_d = is_vram;
            rdata_d   = 32'h0;
            if (is_pal)  rdata_d = {20'h0, pal_q[off[3:0]]};
            if (is_ctrl) rdata_d = ctrl_q;
            if (is_stat) rdata_d = {16'h0, frame_cnt_q, 7'h0, vsync_tog_q};
        end
    end

    always_comb begin
        pix_en_d    = ~pix_en_q;
        h_d         = h_q;
        v_d         = v_q;
        frame_cnt_d = frame_cnt_q;
        vsync_tog_d = vsync_tog_q;
        if (pix_en_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
            end
            if (h_q == '0 && v_q == V_SS) begin
                frame_cnt_d = frame_cnt_q + 8'd1;
                vsync_tog_d = ~vsync_tog_q;
            end
        end

        active = (h_q < H_VISC) && (v_q < V_VISC);
        hs_raw = !((h_q >= H_SS) && (h_q < H_SE));
        vs_raw = !((v_q >= V_SS) && (v_q < V_SE));

        // Both operands are below ROWS while active, so one conditional subtract is a full modulo.
        vrow       = 8'(v_q >> 4);
        eff        = ({3'b0, ctrl_q[28:24]} >= 8'(ROWS)) ? 8'd0 : {3'b0, ctrl_q[28:24]};
        rsum       = vrow + eff;
        trow       = (rsum >= 8'(ROWS)) ? rsum - 8'(ROWS) : rsum;
        fetch_full = 16'(trow) * 16'(COLS / 2) + 16'(h_q >> 4);
        fetch_addr = active ? fetch_full[VA_W-1:0] : '0;

        cur_hit = ctrl_q[16] && (8'(h_q >> 3) == ctrl_q[7:0]) && (vrow == ctrl_q[15:8])
                  && (v_q[3:1] == 3'b111) && (!ctrl_q[17] || !frame_cnt_q[BLINK_LOG2]);
    end

    font_rom u_font (
        .addr ({ch[14:8], s1_row_q}),
        .data (glyph)
    );

    always_comb begin
        ch     = s1_half_q ? vram_a_q[31:16] : vram_a_q[15:0];
        on     = (s2_glyph_q[3'd7 - s2_ctl_q.px] ^ s2_inv_q) || s2_ctl_q.cur;
        colour = on ? s2_fg_q : s2_bg_q;

        s1_ctl_d   = s1_ctl_q;
        s1_half_d  = s1_half_q;
        s1_row_d   = s1_row_q;
        s2_ctl_d   = s2_ctl_q;
        s2_glyph_d = s2_glyph_q;
        s2_inv_d   = s2_inv_q;
        s2_fg_d    = s2_fg_q;
        s2_bg_d    = s2_bg_q;
        red_d      = red_q;
        green_d    = green_q;
        blue_d     = blue_q;
        hs_d       = hs_q;
        vs_d       = vs_q;
        if (pix_en_q) begin
            s1_ctl_d   = '{act: active, hs: hs_raw, vs: vs_raw, cur: cur_hit, px: h_q[2:0]};
            s1_half_d  = h_q[3];
            s1_row_d   = v_q[3:0];
            s2_ctl_d   = s1_ctl_q;
            s2_glyph_d = glyph;
            s2_inv_d   = ch[15];
            s2_fg_d    = pal_q[ch[7:4]];
            s2_bg_d    = pal_q[ch[3:0]];
            red_d      = s2_ctl_q.act ? {colour[11:8], colour[11:8]} : 8'h0;
            green_d    = s2_ctl_q.act ? {colour[7:4], colour[7:4]} : 8'h0;
            blue_d     = s2_ctl_q.act ? {colour[3:0], colour[3:0]} : 8'h0;
            hs_d       = s2_ctl_q.hs;
            vs_d       = s2_ctl_q.vs;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pix_en_q <= 1'b0;  h_q <= '0;  v_q <= '0;
            ctrl_q <= 32'h0;  frame_cnt_q <= 8'h0;  vsync_tog_q <= 1'b0;
            rdata_q <= 32'h0;  rd_vram_q <= 1'b0;
            s1_ctl_q <= CTL_RST;  s1_half_q <= 1'b0;  s1_row_q <= 4'h0;
            s2_ctl_q <= CTL_RST;  s2_glyph_q <= 8'h0;  s2_inv_q <= 1'b0;
            s2_fg_q <= 12'h0;  s2_bg_q <= 12'h0;
            red_q <= 8'h0;  green_q <= 8'h0;  blue_q <= 8'h0;  hs_q <= 1'b1;  vs_q <= 1'b1;
        end else begin
            pix_en_q <= pix_en_d;  h_q <= h_d;  v_q <= v_d;
            ctrl_q <= ctrl_d;  frame_cnt_q <= frame_cnt_d;  vsync_tog_q <= vsync_tog_d;
            rdata_q <= rdata_d;  rd_vram_q <= rd_vram_d;
            s1_ctl_q <= s1_ctl_d;  s1_half_q <= s1_half_d;  s1_row_q <= s1_row_d;
            s2_ctl_q <= s2_ctl_d;  s2_glyph_q <= s2_glyph_d;  s2_inv_q <= s2_inv_d;
            s2_fg_q <= s2_fg_d;  s2_bg_q <= s2_bg_d;
            red_q <= red_d;  green_q <= green_d;  blue_q <= blue_d;  hs_q <= hs_d;  vs_q <= vs_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 16; i++) pal_q[i] <= 12'h0;
        end else if (wr && is_pal) begin
            if (AVL_BYTE_EN[0]) pal_q[off[3:0]][7:0]  <= AVL_WRITEDATA[7:0];
            if (AVL_BYTE_EN[1]) pal_q[off[3:0]][11:8] <= AVL_WRITEDATA[11:8];
        end
    end

    // VRAM keeps its contents across reset; port B serves Avalon, port A the pixel fetch.
    always_ff @(posedge CLK) begin
        if (wr && is_vram) begin
            for (int b = 0; b < 4; b++)
                if (AVL_BYTE_EN[b]) vram[vaddr][b*8 +: 8] <= AVL_WRITEDATA[b*8 +: 8];
        end
        if (rd && is_vram) vram_b_q <= vram[vaddr];
        if (pix_en_q) vram_a_q <= vram[fetch_addr];
    end

    assign AVL_READDATA = rd_vram_q ? vram_b_q : rdata_q;
    assign red   = red_q;
    assign green = green_q;
    assign blue  = blue_q;
    assign hs    = hs_q;
    assign vs    = vs_q;
endmodule

// File: tb/tb_vga_text_pal_avl_interface.sv
// tb/tb_vga_text_pal_avl_interface.sv - directed self-checking bench for vga_text_pal_avl_interface
module tb_vga_text_pal_avl_interface;
    localparam int HT = 56;
    localparam int VT = 54;
    localparam int FRAME = HT * VT * 2;
    localparam logic [11:0] CTRL = 12'h810;
    localparam logic [11:0] STAT = 12'h811;
    localparam logic [23:0] RED  = 24'hFF0000;
    localparam logic [23:0] BLUE = 24'h0000FF;

    logic clk, rst, avl_rd, avl_wr, avl_cs;
    logic [3:0]  avl_be;
    logic [11:0] avl_addr;
    logic [31:0] avl_wdata, avl_rdata;
    logic [7:0]  red, green, blue;
    logic hs, vs;
    int total, bad;

    // Bench timing model: pixel whose colour is currently on the output pins.
    logic m_pe;
    int mh, mv, dh0, dv0, dh1, dv1, dh2, dv2, m_frames;
    logic [2:0] dval;

    vga_text_pal_avl_interface #(
        .COLS(6), .ROWS(3), .ADDR_W(12), .BLINK_LOG2(0),
        .H_VIS(48), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_VIS(48), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut (
        .CLK(clk), .RESET(rst), .AVL_READ(avl_rd), .AVL_WRITE(avl_wr), .AVL_CS(avl_cs),
        .AVL_BYTE_EN(avl_be), .AVL_ADDR(avl_addr), .AVL_WRITEDATA(avl_wdata),
        .AVL_READDATA(avl_rdata), .red(red), .green(green), .blue(blue), .hs(hs), .vs(vs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            m_pe <= 1'b0; mh <= 0; mv <= 0; dval <= 3'b0; m_frames <= 0;
        end else begin
            m_pe <= !m_pe;
            if (m_pe) begin
                if (mh == HT - 1) begin
                    mh <= 0;
                    mv <= (mv == VT - 1) ? 0 : mv + 1;
                end else mh <= mh + 1;
                if (mh == 0 && mv == 50) m_frames <= m_frames + 1;
                dh0 <= mh; dv0 <= mv; dh1 <= dh0; dv1 <= dv0; dh2 <= dh1; dv2 <= dv1;
                dval <= {dval[1:0], 1'b1};
            end
        end
    end

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        avl_addr = a; avl_wdata = d; avl_be = be; avl_cs = 1'b1; avl_wr = 1'b1;
        @(negedge clk);
        avl_cs = 1'b0; avl_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d, output int fr);
        @(negedge clk);
        avl_addr = a; avl_cs = 1'b1; avl_rd = 1'b1; fr = m_frames;
        @(negedge clk);
        avl_cs = 1'b0; avl_rd = 1'b0; d = avl_rdata;
    endtask

    task automatic settle();
        repeat (10) @(negedge clk);
    endtask

    task automatic get_pix(input int h, input int v, output logic [23:0] pix, output logic hs_o, output logic vs_o);
        logic found;
        found = 1'b0; pix = 24'h0; hs_o = 1'b0; vs_o = 1'b0;
        for (int n = 0; n < 2 * FRAME + 200; n++) begin
            @(negedge clk);
            if (dval[2] && dh2 == h && dv2 == v) begin found = 1'b1; break; end
        end
        if (found) begin pix = {red, green, blue}; hs_o = hs; vs_o = vs; end
        else begin total++; bad++; $display("FAIL pixel_timeout h=%0d v=%0d", h, v); end
    endtask

    task automatic test_reset();
        logic [31:0] d; int fr;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if ({red, green, blue} !== 24'h0) begin bad++; $display("FAIL reset_rgb got=%h exp=0", {red, green, blue}); end
        total++; if ({hs, vs} !== 2'b11) begin bad++; $display("FAIL reset_sync got=%b exp=11", {hs, vs}); end
        total++; if (avl_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", avl_rdata); end
        rst = 1'b0;
        bus_read(CTRL, d, fr);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", d); end
        bus_read(STAT, d, fr);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=0", d); end
    endtask

    task automatic test_avalon();
        logic [31:0] d, e; int fr;
        bus_write(12'h803, 32'hFFFF_FABC, 4'b0011);
        bus_read(12'h803, d, fr);
        total++; if (d !== 32'h0000_0ABC) begin bad++; $display("FAIL pal3_be0011 got=%h exp=00000abc", d); end
        bus_write(12'h804, 32'hFFFF_FFFF, 4'b1111);
        bus_read(12'h804, d, fr);
        total++; if (d !== 32'h0000_0FFF) begin bad++; $display("FAIL pal4_hibits got=%h exp=00000fff", d); end
        bus_write(12'h803, 32'h0000_0012, 4'b0010);
        bus_read(12'h803, d, fr);
        total++; if (d !== 32'h0000_00BC) begin bad++; $display("FAIL pal3_lane1 got=%h exp=000000bc", d); end
        bus_write(STAT, 32'hFFFF_FFFF, 4'b1111);
        bus_read(STAT, d, fr);
        e = {16'h0, 8'(fr), 7'h0, 1'(fr % 2)};
        total++; if (d !== e) begin bad++; $display("FAIL status_ro got=%h exp=%h", d, e); end
        bus_write(CTRL, 32'h0003_0205, 4'b1111);
        bus_read(CTRL, d, fr);
        total++; if (d !== 32'h0003_0205) begin bad++; $display("FAIL ctrl_rw got=%h exp=00030205", d); end
        bus_write(CTRL, 32'h0, 4'b1111);
        bus_read(12'h812, d, fr);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_reg got=%h exp=0", d); end
        bus_write(12'h00F, 32'hDEAD_BEEF, 4'b1111);
        bus_read(12'h00F, d, fr);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_vram got=%h exp=0", d); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d; int fr;
        bus_write(12'h000, 32'h1234_5678, 4'b1111);
        bus_write(12'h000, 32'hAA00_0000, 4'b1000);
        bus_read(12'h000, d, fr);
        total++; if (d !== 32'hAA34_5678) begin bad++; $display("FAIL vram_be1000 got=%h exp=aa345678", d); end
        bus_write(12'h000, 32'h00BB_00CC, 4'b0101);
        bus_read(12'h000, d, fr);
        total++; if (d !== 32'hAABB_56CC) begin bad++; $display("FAIL vram_be0101 got=%h exp=aabb56cc", d); end
    endtask

    task automatic test_read_during_write();
        logic [31:0] d; int fr;
        bus_write(12'h001, 32'h1111_1111, 4'b1111);
        @(negedge clk);
        avl_addr = 12'h001; avl_wdata = 32'h2222_2222; avl_be = 4'hF;
        avl_cs = 1'b1; avl_wr = 1'b1; avl_rd = 1'b1;
        @(negedge clk);
        avl_cs = 1'b0; avl_wr = 1'b0; avl_rd = 1'b0; d = avl_rdata;
        total++; if (d !== 32'h1111_1111) begin bad++; $display("FAIL rdw_old got=%h exp=11111111", d); end
        bus_read(12'h001, d, fr);
        total++; if (d !== 32'h2222_2222) begin bad++; $display("FAIL rdw_new got=%h exp=22222222", d); end
    endtask

    task automatic test_pixel();
        logic [23:0] p; logic h_o, v_o;
        bus_write(12'h801, 32'h0000_0F00, 4'b1111);
        bus_write(12'h802, 32'h0000_000F, 4'b1111);
        bus_write(12'h000, 32'h7F21_4112, 4'b1111);
        settle();
        get_pix(0, 0, p, h_o, v_o);
        total++; if (p !== BLUE) begin bad++; $display("FAIL pix_0_0 got=%h exp=%h", p, BLUE); end
        total++; if ({h_o, v_o} !== 2'b11) begin bad++; $display("FAIL sync_0_0 got=%b exp=11", {h_o, v_o}); end
        get_pix(7, 0, p, h_o, v_o);
        total++; if (p !== RED) begin bad++; $display("FAIL pix_7_0 got=%h exp=%h", p, RED); end
        get_pix(8, 0, p, h_o, v_o);
        total++; if (p !== BLUE) begin bad++; $display("FAIL pix_8_0_odd_col got=%h exp=%h", p, BLUE); end
        get_pix(50, 0, p, h_o, v_o);
        total++; if ({p, h_o, v_o} !== {24'h0, 2'b01}) begin bad++; $display("FAIL hsync_start got=%h/%b exp=0/01", p, {h_o, v_o}); end
        get_pix(53, 0, p, h_o, v_o);
        total++; if (h_o !== 1'b0) begin bad++; $display("FAIL hsync_last got=%b exp=0", h_o); end
        get_pix(54, 0, p, h_o, v_o);
        total++; if (h_o !== 1'b1) begin bad++; $display("FAIL hsync_end got=%b exp=1", h_o); end
        get_pix(0, 14, p, h_o, v_o);
        total++; if (p !== RED) begin bad++; $display("FAIL pix_0_14 got=%h exp=%h", p, RED); end
        get_pix(3, 14, p, h_o, v_o);
        total++; if (p !== BLUE) begin bad++; $display("FAIL pix_3_14 got=%h exp=%h", p, BLUE); end
        get_pix(0, 50, p, h_o, v_o);
        total++; if ({p, h_o, v_o} !== {24'h0, 2'b10}) begin bad++; $display("FAIL vsync_start got=%h/%b exp=0/10", p, {h_o, v_o}); end
        get_pix(0, 52, p, h_o, v_o);
        total++; if (v_o !== 1'b1) begin bad++; $display("FAIL vsync_end got=%b exp=1", v_o); end
    endtask

    task automatic test_scroll();
        logic [23:0] p; logic h_o, v_o;
        bus_write(12'h003, 32'h0000_7F10, 4'b1111);
        bus_write(CTRL, 32'h0100_0000, 4'b1111);
        settle();
        get_pix(0, 0, p, h_o, v_o);
        total++; if (p !== RED) begin bad++; $display("FAIL scroll1_row0 got=%h exp=%h", p, RED); end
        bus_write(CTRL, 32'h0200_0000, 4'b1111);
        settle();
        get_pix(0, 16, p, h_o, v_o);
        total++; if (p !== BLUE) begin bad++; $display("FAIL scroll2_row1 got=%h exp=%h", p, BLUE); end
        bus_write(CTRL, 32'h0300_0000, 4'b1111);
        settle();
        get_pix(0, 0, p, h_o, v_o);
        total++; if (p !== BLUE) begin bad++; $display("FAIL scroll3_row0 got=%h exp=%h", p, BLUE); end
        get_pix(0, 16, p, h_o, v_o);
        total++; if (p !== RED) begin bad++; $display("FAIL scroll3_row1 got=%h exp=%h", p, RED); end
        bus_write(CTRL, 32'h1F00_0000, 4'b1111);
        settle();
        get_pix(0, 0, p, h_o, v_o);
        total++; if (p !== BLUE) begin bad++; $display("FAIL scroll31_row0 got=%h exp=%h", p, BLUE); end
    endtask

    task automatic test_cursor();
        logic [23:0] p, e; logic h_o, v_o;
        bus_write(12'h008, 32'h0012_0012, 4'b1111);
        bus_write(CTRL, 32'h0003_0205, 4'b1111);
        settle();
        get_pix(39, 46, p, h_o, v_o);
        total++; if (p !== BLUE) begin bad++; $display("FAIL cursor_left_edge got=%h exp=%h", p, BLUE); end
        get_pix(40, 45, p, h_o, v_o);
        total++; if (p !== BLUE) begin bad++; $display("FAIL cursor_line45 got=%h exp=%h", p, BLUE); end
        for (int k = 0; k < 2; k++) begin
            get_pix(40, 46, p, h_o, v_o);
            e = (m_frames % 2 == 0) ? RED : BLUE;
            total++; if (p !== e) begin bad++; $display("FAIL blink_40_46 frames=%0d got=%h exp=%h", m_frames, p, e); end
            get_pix(47, 47, p, h_o, v_o);
            total++; if (p !== e) begin bad++; $display("FAIL blink_47_47 frames=%0d got=%h exp=%h", m_frames, p, e); end
        end
        bus_write(CTRL, 32'h0001_0205, 4'b1111);
        settle();
        for (int k = 0; k < 2; k++) begin
            get_pix(40, 46, p, h_o, v_o);
            total++; if (p !== RED) begin bad++; $display("FAIL noblink_40_46 frames=%0d got=%h exp=%h", m_frames, p, RED); end
        end
    endtask

    task automatic test_vsync_tog();
        logic [31:0] s1, s2, e; int f1, f2;
        bus_read(STAT, s1, f1);
        repeat (FRAME - 2) @(negedge clk);
        bus_read(STAT, s2, f2);
        e = {16'h0, 8'(f1), 7'h0, 1'(f1 % 2)};
        total++; if (s1 !== e) begin bad++; $display("FAIL status_a got=%h exp=%h", s1, e); end
        e = {16'h0, 8'(f2), 7'h0, 1'(f2 % 2)};
        total++; if (s2 !== e) begin bad++; $display("FAIL status_b got=%h exp=%h", s2, e); end
        total++; if (s2[0] !== ~s1[0]) begin bad++; $display("FAIL vsync_tog_once got=%b exp=%b", s2[0], ~s1[0]); end
        total++; if (s2[15:8] !== s1[15:8] + 8'd1) begin bad++; $display("FAIL frame_cnt_step got=%h exp=%h", s2[15:8], s1[15:8] + 8'd1); end
    endtask

    task automatic test_reset_mid();
        logic [23:0] p; logic h_o, v_o; logic [31:0] d; int fr;
        get_pix(20, 10, p, h_o, v_o);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if ({red, green, blue, hs, vs} !== {24'h0, 2'b11}) begin bad++; $display("FAIL midreset_out got=%h exp=%h", {red, green, blue, hs, vs}, {24'h0, 2'b11}); end
        rst = 1'b0;
        bus_read(CTRL, d, fr);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL midreset_ctrl got=%h exp=0", d); end
        bus_read(STAT, d, fr);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL midreset_status got=%h exp=0", d); end
        bus_read(12'h801, d, fr);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL midreset_pal got=%h exp=0", d); end
        bus_read(12'h000, d, fr);
        total++; if (d !== 32'h7F21_4112) begin bad++; $display("FAIL midreset_vram_kept got=%h exp=7f214112", d); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; avl_rd = 1'b0; avl_wr = 1'b0; avl_cs = 1'b0;
        avl_be = 4'h0; avl_addr = 12'h0; avl_wdata = 32'h0;
        test_reset();
        test_avalon();
        test_byte_lanes();
        test_read_during_write();
        test_pixel();
        test_scroll();
        test_cursor();
        test_vsync_tog();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_text_pal_avl_interface.md
Name: vga_text_pal_avl_interface

Overview:
Parametrised Avalon-MM text-mode VGA controller with on-chip dual-port VRAM, a 16-entry palette, hardware cursor with blink, vertical row scroll and a software-visible vsync status register. It generates its own VGA timing from CLK via a divide-by-2 pixel enable, fetches character/glyph/palette data through a 3-stage pixel pipeline, and delays sync outputs to match. It sits as a Platform Designer slave with the VGA pins exported as a conduit, and uses the existing font_rom (11-bit addr, 8-bit data, combinational).

Parameters:
COLS, 80, text columns (COLS*8 must equal H_VIS)
ROWS, 30, text rows (ROWS*16 must equal V_VIS)
ADDR_W, 12, Avalon word-address width; AVL_ADDR[ADDR_W-1]=1 selects register space
BLINK_LOG2, 5, cursor blink period = 2^(BLINK_LOG2+1) frames
H_VIS/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels
V_VIS/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines

Ports:
CLK  in  1  50 MHz clock, Avalon and pixel domain
RESET  in  1  synchronous, active-high
AVL_READ  in  1  read strobe
AVL_WRITE  in  1  write strobe
AVL_CS  in  1  chip select
AVL_BYTE_EN  in  4  byte enables
AVL_ADDR  in  ADDR_W  word address
AVL_WRITEDATA  in  32  write data
AVL_READDATA  out  32  read data, 1-cycle latency
red, green, blue  out  8 each  pixel colour
hs, vs  out  1 each  syncs, active-low

Behaviour:
- Clock/reset: single clock CLK; RESET synchronous active-high. Reset: pix_en=0, h/v counters=0, CTRL=0, palette=0, frame_cnt=0, vsync_tog=0, pipeline flushed as blank, red/green/blue=0, hs=vs=1, AVL_READDATA=0. VRAM contents not cleared.
- Map (word addr): VRAM 0..COLS*ROWS/2-1 (two chars/word, low half = even column); PAL at R+0..R+15 (R=2^(ADDR_W-1)), bits[11:0]=RGB444; CTRL at R+16; STATUS at R+17 (read-only).
- Char format (16b): [15] inverse, [14:8] glyph code, [7:4] fg palette idx, [3:0] bg palette idx.
- CTRL: [7:0] cursor col, [15:8] cursor row, [16] cursor enable, [17] blink enable, [28:24] scroll row.
- STATUS: [0] vsync_tog, [15:8] frame_cnt[7:0], others 0.
- Writes: when AVL_WRITE&&AVL_CS, each byte lane with BYTE_EN set is written; other lanes unchanged. Writes to STATUS, unmapped addresses, or PAL bits[31:12] are ignored (PAL bits[31:12] read 0).
- Reads: AVL_READ&&AVL_CS at cycle N -> AVL_READDATA valid cycle N+1; unmapped -> 0. Simultaneous AVL_READ and AVL_WRITE to same address: read returns old data.
- Timing: pix_en toggles every CLK; h/v counters advance only on pix_en. h wraps at H_VIS+H_FP+H_SYNC+H_BP-1 -> 0 and increments v; v wraps at total-1 -> 0. Raw hs low while h in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC); vs likewise on v. active = h<H_VIS && v<V_VIS.
- Frame event: on pix_en with h==0 and v==V_VIS+V_FP: frame_cnt+=1 (8-bit wrap), vsync_tog flips.
- Scroll: eff = (CTRL.scroll>=ROWS) ? 0 : scroll; fetched text row = (v/16 + eff) mod ROWS, computed by compare-and-subtract, no divider.
- Pipeline (advances on pix_en): S1 VRAM port-A read address; S2 select half, font_rom addr = code*16 + v[3:0], palette lookup; S3 register colour. hs, vs, active delayed 3 pixel enables. Output 0 when delayed active=0.
- Pixel: on = glyph_bit[7-h[2:0]] ^ inverse. Cursor overrides on=1 when CTRL[16], cell (h/8, v/16) equals (col,row) in screen coords pre-scroll, v[3:0] in {14,15}, and (CTRL[17]==0 or frame_cnt[BLINK_LOG2]==0).
- Colour: on ? PAL[fg] : PAL[bg]; each 4-bit channel c expanded to {c,c}.
- Reset mid-frame: next cycle counters=0, outputs blank, hs=vs=1; Avalon-written state returns to reset values.

Test Plan:
- Reset: hold RESET 3 cycles mid-line -> red/green/blue=0, hs=vs=1, STATUS reads 0, CTRL reads 0.
- Avalon: write PAL[3]=0xFFFF_FABC BE=0011 -> read 0x0000_0ABC one cycle after read strobe; write STATUS -> unchanged.
- Byte lanes: VRAM[0]=0x1234_5678, then write 0xAA00_0000 BE=1000 -> reads 0xAA34_5678.
- Pixel: PAL[1]=0xF00, PAL[2]=0x00F, VRAM[0] low char=0x4112 ('A', fg1 bg2) -> pixel (0,0) row glyph bits produce 0xFF0000 / 0x0000FF exactly 3 pixel enables after h=0, aligned with delayed hs/vs.
- Scroll: CTRL.scroll=1 -> screen row 0 shows text row 1; scroll=29 -> row 1 shows row 0; scroll=31 -> no scroll.
- Cursor/blink: cursor (5,2), enable+blink -> lines 46,47 cols 40-47 fg while frame_cnt[5]=0, bg-driven when 1; vsync_tog flips once per 525 lines.
